myrsp_tx_scheduler: RTL

MYRSP_TX_SCHEDULER -- requirements
Module: myrsp_tx_scheduler

---
 rtl/myrsp_tx_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/myrsp_tx_scheduler.sv
// Turns packetizer length descriptors into UDP header requests, enforcing
// a length check, an in-flight packet credit limit and an inter-packet gap.
module myrsp_tx_scheduler #(
  parameter int          MAX_PACKET_LENGTH = 1400,
  parameter int          HDR_BYTES         = 6,
  parameter int          MAX_OUTSTANDING   = 4,
  parameter logic [15:0] SRC_PORT          = 16'd5000,
  parameter logic [15:0] DST_PORT          = 16'd5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] cfg_ipg,
  input  logic        s_hdr_valid,
  output logic        s_hdr_ready,
  input  logic [15:0] s_hdr_length,
  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [15:0] m_udp_length,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  input  logic        pkt_done,
  output logic        drop,
  output logic [3:0]  outstanding,
  output logic [15:0] pkt_count,
  output logic [15:0] drop_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WAIT_SLOT = 2'd2,
    ISSUE     = 2'd3
  } state_t;

  localparam int         MAX_LEN = MAX_PACKET_LENGTH + HDR_BYTES;
  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  function automatic logic len_bad(input logic [15:0] len);
    len_bad = (len == 16'd0) || (32'(len) > 32'(MAX_LEN));
  endfunction

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] gap_q, gap_d;
  logic        s_hdr_ready_q, s_hdr_ready_d;
  logic        m_valid_q, m_valid_d;
  logic [15:0] m_len_q, m_len_d;
  logic        drop_q, drop_d;
  logic [3:0]  outstanding_q, outstanding_d;
  logic [15:0] pkt_count_q, pkt_count_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic        accept_s;
  logic        issue_hs_s;

  assign accept_s   = s_hdr_valid && s_hdr_ready_q;
  assign issue_hs_s = m_valid_q && m_udp_hdr_ready;

  // Next-state and next-output computation for the scheduler FSM and counters.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    gap_d         = (gap_q != 16'd0) ? (gap_q - 16'd1) : gap_q;
    m_valid_d     = m_valid_q;
    m_len_d       = m_len_q;
    drop_d        = 1'b0;
    pkt_count_d   = pkt_count_q;
    drop_count_d  = drop_count_q;
    outstanding_d = outstanding_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          len_d   = s_hdr_length;
          drop_d  = len_bad(s_hdr_length);
          state_d = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (len_bad(len_q)) begin
          state_d = IDLE;
          if (drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
          end else begin
            drop_count_d = drop_count_q;
          end
        end else begin
          state_d = WAIT_SLOT;
        end
      end
      WAIT_SLOT: begin
        if (enable && (outstanding_q < MAX_OUT) && (gap_q == 16'd0)) begin
          state_d   = ISSUE;
          m_valid_d = 1'b1;
          m_len_d   = len_q;
        end else begin
          state_d = WAIT_SLOT;
        end
      end
      ISSUE: begin
        // Valid is never withdrawn here; only the handshake leaves ISSUE.
        if (issue_hs_s) begin
          m_valid_d   = 1'b0;
          gap_d       = cfg_ipg;
          pkt_count_d = pkt_count_q + 16'd1;
          state_d     = IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      default: begin
        state_d   = IDLE;
        m_valid_d = 1'b0;
      end
    endcase

    if (issue_hs_s && !pkt_done) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (!issue_hs_s && pkt_done && (outstanding_q != 4'd0)) begin
      outstanding_d = outstanding_q - 4'd1;
    end else begin
      outstanding_d = outstanding_q;
    end

    s_hdr_ready_d = (state_d == IDLE);
  end

  // State and registered-output flops with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      len_q         <= 16'd0;
      gap_q         <= 16'd0;
      s_hdr_ready_q <= 1'b0;
      m_valid_q     <= 1'b0;
      m_len_q       <= 16'd0;
      drop_q        <= 1'b0;
      outstanding_q <= 4'd0;
      pkt_count_q   <= 16'd0;
      drop_count_q  <= 16'd0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      gap_q         <= gap_d;
      s_hdr_ready_q <= s_hdr_ready_d;
      m_valid_q     <= m_valid_d;
      m_len_q       <= m_len_d;
      drop_q        <= drop_d;
      outstanding_q <= outstanding_d;
      pkt_count_q   <= pkt_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign s_hdr_ready       = s_hdr_ready_q;
  assign m_udp_hdr_valid   = m_valid_q;
  assign m_udp_length      = m_len_q;
  assign m_udp_source_port = SRC_PORT;
  assign m_udp_dest_port   = DST_PORT;
  assign drop              = drop_q;
  assign outstanding       = outstanding_q;
  assign pkt_count         = pkt_count_q;
  assign drop_count        = drop_count_q;

endmodule
